bilinear_coord_gen: RTL and testbench
=====================================

Name: bilinear_coord_gen

Overview:
- Source side of the bilinear scaler datapath; the pixel-interpolation stage consumes its outputs.
- For each frame it walks every destination pixel in raster order.
- Per pixel it emits the integer source window corners (x0,y0)/(x1,y1), which the line-buffer fetch logic uses, plus the four fixed-point weights w00..w11.
- Per-frame scale factors are computed by an internal sequential divider. Output is a valid/ready stream.

Parameters:
- FIX_WIDTH, 12, fractional bits of scale accumulators and weights.
- DIM_WIDTH, 16, width of all dimension and coordinate signals.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  frame start pulse; ignored while busy_o=1.
- src_width_i  in  DIM_WIDTH  source width; sampled when start_i is accepted.
- src_height_i  in  DIM_WIDTH  source height; sampled at start.
- dest_width_i  in  DIM_WIDTH  destination width; sampled at start.
- dest_height_i  in  DIM_WIDTH  destination height; sampled at start.
- busy_o  out  1  high from start acceptance until frame end.
- done_o  out  1  one-cycle pulse at frame end.
- tready_i  in  1  downstream ready.
- tvalid_o  out  1  output beat valid.
- x0_o, x1_o, y0_o, y1_o  out  DIM_WIDTH each  source window corners.
- weight00_o, weight01_o, weight10_o, weight11_o  out  FIX_WIDTH each  bilinear weights.
- sof_o  out  1  marks the beat for destination pixel (0,0).
- eol_o  out  1  marks the beat for dx = dest_width-1.

Behaviour:
- Reset (async): all outputs 0, FSM=IDLE, all counters and accumulators 0. Asserting rst_i mid-frame drops tvalid_o and busy_o immediately. No frame resumes after reset; a new start_i is required.
- States: IDLE -> DIVX -> DIVY -> LOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - start_i=1: latch all four dimensions and set busy_o=1.
  - If any latched dimension is 0, go to DONE directly (no beats).
  - Otherwise go to DIVX.
- DIVX: restoring divider, exactly DIM_WIDTH+FIX_WIDTH cycles (28 by default).
  - scale_x = floor((src_w << FIX_WIDTH) / dest_w).
  - Scale register width is DIM_WIDTH+FIX_WIDTH.
- DIVY: same divider, same cycle count, computing scale_y from src_h and dest_h.
- LOAD: one cycle. Registers the beat for pixel (0,0) and sets tvalid_o=1 on the next edge.
  - Latency: start_i accepted at edge N -> tvalid_o high after edge N+2*(DIM_WIDTH+FIX_WIDTH)+1 (N+57 by default).
- Per-pixel math:
  - acc_x = dx*scale_x and acc_y = dy*scale_y, built by accumulation only (no multiplier on dx/dy).
  - x0 = min(acc_x >> FIX_WIDTH, src_w-1); x1 = min(x0+1, src_w-1). y0 and y1 are formed the same way.
  - fx = acc_x[FIX_WIDTH-1:0] and fy = acc_y[FIX_WIDTH-1:0], each forced to 0 whenever the corresponding x0/y0 was clamped.
  - With ONE = 2^FIX_WIDTH, each weight is a (FIX_WIDTH+1)x(FIX_WIDTH+1) product >> FIX_WIDTH, saturated to 2^FIX_WIDTH-1:
    - w00 = (ONE-fx)*(ONE-fy)
    - w01 = fx*(ONE-fy)
    - w10 = (ONE-fx)*fy
    - w11 = fx*fy
- RUN handshake:
  - A beat transfers when tvalid_o && tready_i.
  - While tvalid_o=1 && tready_i=0, all outputs hold stable.
  - On transfer, the next pixel's beat is registered in the same edge, so throughput is 1 beat/cycle with tready_i held high.
- Raster advance:
  - dx increments and acc_x += scale_x.
  - At dx = dest_w-1: dx=0, acc_x=0, dy increments, acc_y += scale_y.
- Frame end: on transfer of pixel (dest_w-1, dest_h-1), the next edge gives tvalid_o=0 and FSM=DONE.
- DONE: one cycle. done_o=1, busy_o drops at the following edge, FSM returns to IDLE. A start_i in the DONE cycle is ignored.
- sof_o and eol_o are valid only while tvalid_o=1, and are held with the data.
- Dimension inputs are don't-care outside the start acceptance cycle.

Test Plan:
- Identity 4x4->4x4, tready_i=1:
  - scale_x = scale_y = 4096; 16 contiguous beats.
  - Every beat: x0=dx, x1=min(dx+1,3), w00=4095, w01=w10=w11=0.
  - done_o pulses 1 cycle after the last beat.
- Upscale 2x2->4x4:
  - scale = 2048.
  - Beat (1,0): x0=0, x1=1, w00=2048, w01=2048, w10=w11=0.
  - Beat (3,3): x0=x1=1, y0=y1=1, w00=4095.
  - Beat (1,1): all four weights 1024.
- Latency and flags:
  - start_i at edge 0 -> first tvalid_o after edge 57, with sof_o=1.
  - eol_o=1 on beats dx=3.
  - For 4x4 with tready_i=1, the last beat is at edge 72 and done_o at edge 73.
- Backpressure with tready_i randomly toggled 50%:
  - Outputs are stable while stalled; no beat is skipped or duplicated.
  - Exactly dest_w*dest_h beats; the sequence matches the no-stall run.
- Zero dimension, dest_width_i=0:
  - No tvalid_o.
  - done_o pulses within 2 cycles of start.
  - A start_i during busy_o is ignored.
- Reset mid-frame: assert rst_i during RUN of a 1920x1080->640x360 frame.
  - tvalid_o, busy_o and all outputs go to 0 asynchronously.
  - A restart produces a first beat with sof_o=1 and scale_x=12288.
  - Beat dx=1 has x0=3, fx=0.

Source files
------------

// File: rtl/bilinear_coord_gen.sv
// Bilinear scaler source-coordinate generator: per-frame scale division, then a raster
// walk emitting source window corners and fixed-point weights on a valid/ready stream.
module bilinear_coord_gen #(
  parameter int unsigned FIX_WIDTH = 12,
  parameter int unsigned DIM_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DIM_WIDTH-1:0] src_width_i,
  input  logic [DIM_WIDTH-1:0] src_height_i,
  input  logic [DIM_WIDTH-1:0] dest_width_i,
  input  logic [DIM_WIDTH-1:0] dest_height_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 tready_i,
  output logic                 tvalid_o,
  output logic [DIM_WIDTH-1:0] x0_o,
  output logic [DIM_WIDTH-1:0] x1_o,
  output logic [DIM_WIDTH-1:0] y0_o,
  output logic [DIM_WIDTH-1:0] y1_o,
  output logic [FIX_WIDTH-1:0] weight00_o,
  output logic [FIX_WIDTH-1:0] weight01_o,
  output logic [FIX_WIDTH-1:0] weight10_o,
  output logic [FIX_WIDTH-1:0] weight11_o,
  output logic                 sof_o,
  output logic                 eol_o
);

  localparam int unsigned SW = DIM_WIDTH + FIX_WIDTH;
  localparam int unsigned AW = DIM_WIDTH + SW;
  localparam int unsigned CW = $clog2(SW);

  typedef enum logic [2:0] {S_IDLE, S_DIVX, S_DIVY, S_LOAD, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [DIM_WIDTH-1:0] c0;
    logic [DIM_WIDTH-1:0] c1;
    logic [FIX_WIDTH-1:0] f;
  } axis_t;

  state_t               state_q;
  logic [DIM_WIDTH-1:0] src_w_q, src_h_q, dst_w_q, dst_h_q;
  logic [SW-1:0]        div_q_q, scale_x_q, scale_y_q;
  logic [DIM_WIDTH-1:0] div_r_q;
  logic [CW-1:0]        div_cnt_q;
  logic [DIM_WIDTH-1:0] dx_q, dy_q, dx_d, dy_d;
  logic [AW-1:0]        acc_x_q, acc_y_q, acc_x_d, acc_y_d;

  // Coordinates at or past the last source column/row collapse to an edge pixel with no fraction.
  function automatic axis_t map_axis(input logic [AW-1:0] acc, input logic [DIM_WIDTH-1:0] size);
    logic [AW-FIX_WIDTH-1:0] ipart;
    logic [DIM_WIDTH-1:0]    last;
    axis_t                   r;
    ipart = acc[AW-1:FIX_WIDTH];
    last  = size - DIM_WIDTH'(1);
    if (ipart >= (AW-FIX_WIDTH)'(last)) begin
      r.c0 = last;
      r.f  = '0;
    end else begin
      r.c0 = ipart[DIM_WIDTH-1:0];
      r.f  = acc[FIX_WIDTH-1:0];
    end
    r.c1 = (r.c0 == last) ? r.c0 : r.c0 + DIM_WIDTH'(1);
    return r;
  endfunction

  function automatic logic [FIX_WIDTH-1:0] wmul(input logic [FIX_WIDTH:0] a, input logic [FIX_WIDTH:0] b);
    logic [2*FIX_WIDTH+1:0] p;
    p = {{(FIX_WIDTH+1){1'b0}}, a} * {{(FIX_WIDTH+1){1'b0}}, b};
    if (|p[2*FIX_WIDTH+1:2*FIX_WIDTH]) return '1;
    return p[2*FIX_WIDTH-1:FIX_WIDTH];
  endfunction

  // Restoring divider step: shift one dividend bit into the partial remainder per cycle.
  logic [DIM_WIDTH-1:0] div_den;
  logic [DIM_WIDTH:0]   div_trial, div_diff;
  logic                 div_ge;
  logic [DIM_WIDTH-1:0] div_r_d;
  logic [SW-1:0]        div_q_d;
  logic                 div_last;

  assign div_den   = (state_q == S_DIVY) ? dst_h_q : dst_w_q;
  assign div_trial = {div_r_q, div_q_q[SW-1]};
  assign div_diff  = div_trial - {1'b0, div_den};
  assign div_ge    = div_trial >= {1'b0, div_den};
  assign div_r_d   = div_ge ? div_diff[DIM_WIDTH-1:0] : div_trial[DIM_WIDTH-1:0];
  assign div_q_d   = {div_q_q[SW-2:0], div_ge};
  assign div_last  = div_cnt_q == CW'(SW - 1);

  logic last_col, last_row, xfer, load_beat;
  assign last_col  = dx_q == dst_w_q - DIM_WIDTH'(1);
  assign last_row  = dy_q == dst_h_q - DIM_WIDTH'(1);
  assign xfer      = tvalid_o && tready_i;
  assign load_beat = (state_q == S_LOAD) || (state_q == S_RUN && xfer && !(last_col && last_row));

  always_comb begin
    dx_d    = '0;
    dy_d    = '0;
    acc_x_d = '0;
    acc_y_d = '0;
    if (state_q == S_RUN) begin
      if (last_col) begin
        dy_d    = dy_q + DIM_WIDTH'(1);
        acc_y_d = acc_y_q + AW'(scale_y_q);
      end else begin
        dx_d    = dx_q + DIM_WIDTH'(1);
        dy_d    = dy_q;
        acc_x_d = acc_x_q + AW'(scale_x_q);
        acc_y_d = acc_y_q;
      end
    end
  end

  axis_t              ax, ay;
  logic [FIX_WIDTH:0] fx_e, fy_e, ofx, ofy;
  assign ax   = map_axis(acc_x_d, src_w_q);
  assign ay   = map_axis(acc_y_d, src_h_q);
  assign fx_e = {1'b0, ax.f};
  assign fy_e = {1'b0, ay.f};
  assign ofx  = {1'b1, {FIX_WIDTH{1'b0}}} - fx_e;
  assign ofy  = {1'b1, {FIX_WIDTH{1'b0}}} - fy_e;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      src_w_q <= '0; src_h_q <= '0; dst_w_q <= '0; dst_h_q <= '0;
      div_q_q <= '0; div_r_q <= '0; div_cnt_q <= '0;
      scale_x_q <= '0; scale_y_q <= '0;
      dx_q <= '0; dy_q <= '0; acc_x_q <= '0; acc_y_q <= '0;
      busy_o <= 1'b0; done_o <= 1'b0; tvalid_o <= 1'b0;
      x0_o <= '0; x1_o <= '0; y0_o <= '0; y1_o <= '0;
      weight00_o <= '0; weight01_o <= '0; weight10_o <= '0; weight11_o <= '0;
      sof_o <= 1'b0; eol_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            src_w_q <= src_width_i;
            src_h_q <= src_height_i;
            dst_w_q <= dest_width_i;
            dst_h_q <= dest_height_i;
            busy_o  <= 1'b1;
            if (src_width_i == '0 || src_height_i == '0 || dest_width_i == '0 || dest_height_i == '0) begin
              done_o  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              div_q_q   <= {src_width_i, {FIX_WIDTH{1'b0}}};
              div_r_q   <= '0;
              div_cnt_q <= '0;
              state_q   <= S_DIVX;
            end
          end
        end
        S_DIVX, S_DIVY: begin
          div_q_q   <= div_q_d;
          div_r_q   <= div_r_d;
          div_cnt_q <= div_cnt_q + CW'(1);
          if (div_last) begin
            div_r_q   <= '0;
            div_cnt_q <= '0;
            if (state_q == S_DIVX) begin
              scale_x_q <= div_q_d;
              div_q_q   <= {src_h_q, {FIX_WIDTH{1'b0}}};
              state_q   <= S_DIVY;
            end else begin
              scale_y_q <= div_q_d;
              state_q   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          tvalid_o <= 1'b1;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          if (xfer && last_col && last_row) begin
            tvalid_o <= 1'b0;
            done_o   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (load_beat) begin
        dx_q       <= dx_d;
        dy_q       <= dy_d;
        acc_x_q    <= acc_x_d;
        acc_y_q    <= acc_y_d;
        x0_o       <= ax.c0;
        x1_o       <= ax.c1;
        y0_o       <= ay.c0;
        y1_o       <= ay.c1;
        weight00_o <= wmul(ofx, ofy);
        weight01_o <= wmul(fx_e, ofy);
        weight10_o <= wmul(ofx, fy_e);
        weight11_o <= wmul(fx_e, fy_e);
        sof_o      <= (dx_d == '0) && (dy_d == '0);
        eol_o      <= dx_d == dst_w_q - DIM_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_bilinear_coord_gen.sv
// Scoreboard bench for bilinear_coord_gen: expected beats come from plain-arithmetic
// bilinear mapping; a negedge monitor pops and compares on every transfer.
module tb_bilinear_coord_gen;

  localparam int FW = 12;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] x0, x1, y0, y1;
    logic [FW-1:0] w00, w01, w10, w11;
    logic          sof, eol;
  } beat_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic tready_i = 1'b0;
  logic [DW-1:0] src_width_i = '0, src_height_i = '0, dest_width_i = '0, dest_height_i = '0;
  logic busy_o, done_o, tvalid_o, sof_o, eol_o;
  logic [DW-1:0] x0_o, x1_o, y0_o, y1_o;
  logic [FW-1:0] weight00_o, weight01_o, weight10_o, weight11_o;

  bilinear_coord_gen #(.FIX_WIDTH(FW), .DIM_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .src_width_i(src_width_i), .src_height_i(src_height_i),
    .dest_width_i(dest_width_i), .dest_height_i(dest_height_i),
    .busy_o(busy_o), .done_o(done_o), .tready_i(tready_i), .tvalid_o(tvalid_o),
    .x0_o(x0_o), .x1_o(x1_o), .y0_o(y0_o), .y1_o(y1_o),
    .weight00_o(weight00_o), .weight01_o(weight01_o),
    .weight10_o(weight10_o), .weight11_o(weight11_o),
    .sof_o(sof_o), .eol_o(eol_o)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  bit    bp_mode = 1'b0;
  bit    force_stall = 1'b0;

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic string fmt(input beat_t b);
    return $sformatf("x0=%0d x1=%0d y0=%0d y1=%0d w=%0d/%0d/%0d/%0d sof=%0d eol=%0d",
                     b.x0, b.x1, b.y0, b.y1, b.w00, b.w01, b.w10, b.w11, b.sof, b.eol);
  endfunction

  // Map destination index d to source window along one axis.
  function automatic void axis(input longint n, input longint m, input longint d,
                               output longint c0, output longint c1, output longint f);
    longint scale, pos, ip;
    scale = (n * 4096) / m;
    pos   = d * scale;
    ip    = pos / 4096;
    if (ip >= n - 1) begin
      c0 = n - 1;
      f  = 0;
    end else begin
      c0 = ip;
      f  = pos % 4096;
    end
    c1 = (c0 + 1 < n) ? c0 + 1 : n - 1;
  endfunction

  function automatic longint wt(input longint a, input longint b);
    longint v;
    v = (a * b) / 4096;
    return (v > 4095) ? 4095 : v;
  endfunction

  function automatic beat_t model(input int sw, input int sh, input int dw, input int dh,
                                  input int dx, input int dy);
    longint x0, x1, fx, y0, y1, fy;
    beat_t  b;
    axis(sw, dw, dx, x0, x1, fx);
    axis(sh, dh, dy, y0, y1, fy);
    b.x0  = DW'(x0); b.x1 = DW'(x1); b.y0 = DW'(y0); b.y1 = DW'(y1);
    b.w00 = FW'(wt(4096 - fx, 4096 - fy));
    b.w01 = FW'(wt(fx, 4096 - fy));
    b.w10 = FW'(wt(4096 - fx, fy));
    b.w11 = FW'(wt(fx, fy));
    b.sof = (dx == 0) && (dy == 0);
    b.eol = (dx == dw - 1);
    return b;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    tready_i = force_stall ? 1'b0 : (bp_mode ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: compare on transfer, and check outputs hold while stalled.
  initial begin : monitor
    beat_t cur, held_b, e;
    bit    held;
    int    nbeat;
    held  = 1'b0;
    nbeat = 0;
    forever begin
      @(negedge clk);
      if (rst_i || !tvalid_o) begin
        held = 1'b0;
      end else begin
        cur = '{x0_o, x1_o, y0_o, y1_o, weight00_o, weight01_o, weight10_o, weight11_o, sof_o, eol_o};
        if (held) begin
          tests++;
          if (cur != held_b) begin
            fails++;
            $display("FAIL stall_hold: got %s, expected %s", fmt(cur), fmt(held_b));
          end
        end
        if (tready_i) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got %s, expected no beat", fmt(cur));
          end else begin
            e = exp_q.pop_front();
            if (cur != e) begin
              fails++;
              $display("FAIL beat%0d: got %s, expected %s", nbeat, fmt(cur), fmt(e));
            end
          end
          nbeat++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_b = cur;
        end
      end
    end
  end

  task automatic start_frame(input int sw, input int sh, input int dw, input int dh, input int npush);
    int n;
    n = 0;
    if (sw > 0 && sh > 0)
      for (int dy = 0; dy < dh; dy++)
        for (int dx = 0; dx < dw; dx++)
          if (n < npush) begin
            exp_q.push_back(model(sw, sh, dw, dh, dx, dy));
            n++;
          end
    @(posedge clk); #2;
    src_width_i   = DW'(sw);
    src_height_i  = DW'(sh);
    dest_width_i  = DW'(dw);
    dest_height_i = DW'(dh);
    start_i = 1'b1;
    @(posedge clk); #2;
    start_i       = 1'b0;
    src_width_i   = DW'($urandom);
    src_height_i  = DW'($urandom);
    dest_width_i  = DW'($urandom);
    dest_height_i = DW'($urandom);
  endtask

  task automatic run_frame(input int sw, input int sh, input int dw, input int dh,
                           output int first_v, output int done_at);
    int cyc, budget;
    start_frame(sw, sh, dw, dh, dw * dh);
    budget  = 200 + 4 * dw * dh;
    first_v = -1;
    done_at = -1;
    cyc     = 0;
    forever begin
      if (tvalid_o && first_v < 0) first_v = cyc;
      if (done_o) begin
        done_at = cyc;
        break;
      end
      if (cyc >= budget) break;
      if (cyc == 5) begin
        start_i = 1'b1;
        src_width_i = 16'd7; src_height_i = 16'd5; dest_width_i = 16'd3; dest_height_i = 16'd2;
      end
      if (cyc == 6) start_i = 1'b0;
      @(posedge clk); #2;
      cyc++;
    end
    check("done_seen", done_at >= 0, 1);
    check("all_beats_sent", exp_q.size(), 0);
    check("tvalid_low_at_done", tvalid_o, 0);
    start_i = 1'b1;
    src_width_i = 16'd3; src_height_i = 16'd3; dest_width_i = 16'd3; dest_height_i = 16'd3;
    @(posedge clk); #2;
    start_i = 1'b0;
    check("busy_after_done", busy_o, 0);
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("drain_in_time", exp_q.size(), 0);
  endtask

  task automatic reset_now();
    force_stall = 1'b1;
    tready_i    = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    check("rst_tvalid", tvalid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_coords", {x0_o, x1_o, y0_o, y1_o}, 0);
    check("rst_weights", {weight00_o, weight01_o, weight10_o, weight11_o}, 0);
    check("rst_flags", {sof_o, eol_o}, 0);
    exp_q.delete();
    @(posedge clk); #2;
    rst_i       = 1'b0;
    force_stall = 1'b0;
  endtask

  initial begin : stim
    int fv, da;
    repeat (3) @(posedge clk);
    #2;
    check("init_tvalid", tvalid_o, 0);
    check("init_busy", busy_o, 0);
    check("init_outs", {x0_o, y1_o, weight00_o, weight11_o, sof_o, eol_o}, 0);
    rst_i = 1'b0;

    bp_mode = 1'b0;
    run_frame(4, 4, 4, 4, fv, da);
    check("identity_first_valid_edge", fv, 57);
    check("identity_done_edge", da, 73);

    run_frame(2, 2, 4, 4, fv, da);
    check("upscale_first_valid_edge", fv, 57);

    bp_mode = 1'b1;
    run_frame(4, 4, 4, 4, fv, da);
    run_frame(2, 2, 4, 4, fv, da);
    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(1, 40), $urandom_range(1, 40),
                $urandom_range(1, 12), $urandom_range(1, 12), fv, da);
    run_frame(1000, 3, 3, 7, fv, da);
    run_frame(1, 1, 5, 2, fv, da);

    bp_mode = 1'b0;
    run_frame(4, 4, 0, 4, fv, da);
    check("zero_dim_no_valid", fv, -1);
    check("zero_dim_done_fast", (da >= 0 && da <= 2), 1);

    start_frame(1920, 1080, 640, 360, 700);
    drain(1000);
    check("mid_frame_busy", busy_o, 1);
    reset_now();
    start_frame(1920, 1080, 640, 360, 5);
    drain(200);
    reset_now();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule
